// File: rtl/mem_responder.sv
// mem_responder: memory-side responder between the cpu's two request ports
// and one single-port synchronous RAM.
//
//   Port A : instruction fetch (read only)
//   Port B : data load / store
//
// Requests are arbitrated round-robin and serialised onto the RAM through a
// four-state FSM (IDLE -> ACCESS -> WAIT -> RESP). WAIT lasts 1+WAIT_STATES
// cycles to model slower memory. One access takes 4+WAIT_STATES cycles from
// grant to the next grant decision.
//
// Optional feature, enabled by defining MEM_RESP_ADDR_CHECK_EN:
//   a granted request whose address has any bit set above the RAM index
//   range is answered immediately with ack + err and zero read data, and
//   never reaches the RAM. Without the macro the upper address bits are
//   ignored (the RAM aliases) and the err outputs stay 0.
//
// Every output comes straight from a register.

module mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int WAIT_STATES    = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,

    // Port A: instruction fetch
    input  logic                      a_req_in,
    input  logic [ADDR_WIDTH-1:0]     a_addr_in,
    output logic                      a_ack_out,
    output logic [DATA_WIDTH-1:0]     a_rdata_out,
    output logic                      a_err_out,

    // Port B: data load / store
    input  logic                      b_req_in,
    input  logic                      b_we_in,
    input  logic [ADDR_WIDTH-1:0]     b_addr_in,
    input  logic [DATA_WIDTH-1:0]     b_wdata_in,
    output logic                      b_ack_out,
    output logic [DATA_WIDTH-1:0]     b_rdata_out,
    output logic                      b_err_out,

    // Single-port synchronous RAM
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
    output logic                      ram_we_out,
    output logic [DATA_WIDTH-1:0]     ram_din_out,
    input  logic [DATA_WIDTH-1:0]     ram_dout_in
);

    // Wait-state count as loaded into the 4-bit down counter.
    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    // Port identifiers used for the latched grant and the round-robin pointer.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                    r_state;
    logic                      r_last_grant;   // port served most recently
    logic                      r_port;         // port owning the current access
    logic                      r_we;           // current access is a store
    logic [3:0]                r_cnt;          // remaining extra wait cycles

    logic                      r_a_ack;
    logic [DATA_WIDTH-1:0]     r_a_rdata;
    logic                      r_a_err;
    logic                      r_b_ack;
    logic [DATA_WIDTH-1:0]     r_b_rdata;
    logic                      r_b_err;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
    logic                      r_ram_we;
    logic [DATA_WIDTH-1:0]     r_ram_din;

    // ------------------------------------------------------------------
    // Arbitration (evaluated only while IDLE)
    // ------------------------------------------------------------------
    // A request is ignored in the very cycle its own ack is shown, so a
    // requester that is slow to drop req does not get a second access.
    logic                      w_a_elig;
    logic                      w_b_elig;
    logic                      w_grant_any;
    logic                      w_grant_b;
    logic [ADDR_WIDTH-1:0]     w_gnt_addr;
    logic                      w_gnt_we;
    logic [DATA_WIDTH-1:0]     w_gnt_wdata;
    logic                      w_addr_bad;

    assign w_a_elig    = a_req_in & ~r_a_ack;
    assign w_b_elig    = b_req_in & ~r_b_ack;
    assign w_grant_any = w_a_elig | w_b_elig;

    // B wins when it is the only requester, or when both contend and A was
    // served last; otherwise A wins. After reset last_grant is A, so B wins
    // the first contention.
    assign w_grant_b   = w_b_elig & (~w_a_elig | (r_last_grant == PORT_A));

    // Port A never writes; its store-data path is forced to zero.
    assign w_gnt_addr  = w_grant_b ? b_addr_in : a_addr_in;
    assign w_gnt_we    = w_grant_b & b_we_in;
    assign w_gnt_wdata = w_grant_b ? b_wdata_in : '0;

`ifdef MEM_RESP_ADDR_CHECK_EN
    // Any address bit above the RAM index range marks the request as invalid.
    assign w_addr_bad = |w_gnt_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
`else
    // Upper address bits are ignored: the RAM simply aliases.
    logic w_unused_upper;
    assign w_addr_bad     = 1'b0;
    assign w_unused_upper = ^w_gnt_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
`endif

    // ------------------------------------------------------------------
    // Main FSM with registered outputs
    // ------------------------------------------------------------------
    // Acks, errs and the RAM write strobe default low every cycle so they
    // can only ever be single-cycle pulses; rdata and RAM address/data
    // registers hold unless explicitly loaded.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_last_grant <= PORT_A;
            r_port       <= PORT_A;
            r_we         <= 1'b0;
            r_cnt        <= 4'd0;
            r_a_ack      <= 1'b0;
            r_a_rdata    <= '0;
            r_a_err      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_b_rdata    <= '0;
            r_b_err      <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_din    <= '0;
        end else begin
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
            r_ram_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_port       <= w_grant_b;
                        r_last_grant <= w_grant_b;
                        r_we         <= w_gnt_we;
                        if (w_addr_bad) begin
                            // Out-of-range request: answer at once with an
                            // error and zero data, RAM untouched.
                            r_state <= S_RESP;
                            if (w_grant_b) begin
                                r_b_ack   <= 1'b1;
                                r_b_err   <= 1'b1;
                                r_b_rdata <= '0;
                            end else begin
                                r_a_ack   <= 1'b1;
                                r_a_err   <= 1'b1;
                                r_a_rdata <= '0;
                            end
                        end else begin
                            // Present the access to the RAM during ACCESS.
                            r_state    <= S_ACCESS;
                            r_ram_addr <= w_gnt_addr[RAM_ADDR_WIDTH-1:0];
                            r_ram_we   <= w_gnt_we;
                            r_ram_din  <= w_gnt_wdata;
                        end
                    end
                end

                S_ACCESS: begin
                    // The write strobe drops by default; the address is held
                    // through WAIT so the read data stays valid.
                    r_state <= S_WAIT;
                    r_cnt   <= LP_WAIT;
                end

                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_port == PORT_B) begin
                            r_b_ack <= 1'b1;
                            // Stores leave the previous load data in place.
                            if (!r_we) begin
                                r_b_rdata <= ram_dout_in;
                            end
                        end else begin
                            r_a_ack   <= 1'b1;
                            r_a_rdata <= ram_dout_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    // Ack is visible this cycle; arbitration resumes next.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign a_ack_out    = r_a_ack;
    assign a_rdata_out  = r_a_rdata;
    assign a_err_out    = r_a_err;
    assign b_ack_out    = r_b_ack;
    assign b_rdata_out  = r_b_rdata;
    assign b_err_out    = r_b_err;
    assign ram_addr_out = r_ram_addr;
    assign ram_we_out   = r_ram_we;
    assign ram_din_out  = r_ram_din;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder.
// Two instances: dut0 with WAIT_STATES=0 carries most tests, dut3 with
// WAIT_STATES=3 checks the stretched timing. Each drives its own RAM model
// (synchronous write, registered read). Stimulus pushes the expected ack
// into a scoreboard queue; a monitor pops and compares on every ack.
// Expectations follow MEM_RESP_ADDR_CHECK_EN when it is defined.
`timescale 1ns/1ps

module tb_mem_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;

    // Cycle counter: at a negedge, cyc names the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut0 (WAIT_STATES=0) ----------------
    logic          a_req, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] b_wdata;
    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [RW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din, ram_dout;

    // ---------------- dut3 (WAIT_STATES=3) ----------------
    logic          a3_req;
    logic [AW-1:0] a3_addr;
    logic          a3_ack, a3_err, b3_ack, b3_err;
    logic [DW-1:0] a3_rdata, b3_rdata;
    logic [RW-1:0] ram3_addr;
    logic          ram3_we;
    logic [DW-1:0] ram3_din, ram3_dout;

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(RW), .WAIT_STATES(0)) dut0 (
        .clk_in(clk), .rst_in(rst_n),
        .a_req_in(a_req), .a_addr_in(a_addr), .a_ack_out(a_ack), .a_rdata_out(a_rdata), .a_err_out(a_err),
        .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
        .b_ack_out(b_ack), .b_rdata_out(b_rdata), .b_err_out(b_err),
        .ram_addr_out(ram_addr), .ram_we_out(ram_we), .ram_din_out(ram_din), .ram_dout_in(ram_dout)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(RW), .WAIT_STATES(3)) dut3 (
        .clk_in(clk), .rst_in(rst_n),
        .a_req_in(a3_req), .a_addr_in(a3_addr), .a_ack_out(a3_ack), .a_rdata_out(a3_rdata), .a_err_out(a3_err),
        .b_req_in(1'b0), .b_we_in(1'b0), .b_addr_in('0), .b_wdata_in('0),
        .b_ack_out(b3_ack), .b_rdata_out(b3_rdata), .b_err_out(b3_err),
        .ram_addr_out(ram3_addr), .ram_we_out(ram3_we), .ram_din_out(ram3_din), .ram_dout_in(ram3_dout)
    );

    // ---------------- RAM models ----------------
    logic [DW-1:0] mem0 [0:(1<<RW)-1];
    logic [DW-1:0] mem3 [0:(1<<RW)-1];
    logic          preloaded = 1'b0;

    // First edge preloads the test words; afterwards behave as sync RAMs.
    always @(posedge clk) begin
        if (!preloaded) begin
            mem0[16]  <= 32'hDEADBEEF;
            mem3[16]  <= 32'h0BADF00D;
            preloaded <= 1'b1;
        end else begin
            if (ram_we)  mem0[ram_addr]  <= ram_din;
            if (ram3_we) mem3[ram3_addr] <= ram3_din;
        end
        ram_dout  <= mem0[ram_addr];
        ram3_dout <= mem3[ram3_addr];
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut;
        bit          port_b;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int            we_cnt0 = 0;
    int            last_we_cyc0 = 0;
    logic [RW-1:0] last_we_addr0 = '0;
    logic [DW-1:0] last_we_din0 = '0;
    int            we_cnt3 = 0;

    // Record every RAM write strobe on dut0 / dut3.
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt0       <= we_cnt0 + 1;
            last_we_cyc0  <= cyc;
            last_we_addr0 <= ram_addr;
            last_we_din0  <= ram_din;
        end
        if (ram3_we) we_cnt3 <= we_cnt3 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_ack(input int d, input bit pb, input logic [31:0] rd, input logic er);
        exp_t e;
        $display("ack dut=%0d port=%s cyc=%0d rdata=%h err=%0b", d, pb ? "B" : "A", cyc, rd, er);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ack dut=%0d port_b=%0d cyc=%0d got ack, exp none", d, pb, cyc);
        end else begin
            e = sb.pop_front();
            if (e.dut != d || e.port_b != pb || e.cyc != cyc) begin
                bad++;
                $display("FAIL ack_timing got dut=%0d port_b=%0d cyc=%0d exp dut=%0d port_b=%0d cyc=%0d",
                         d, pb, cyc, e.dut, e.port_b, e.cyc);
            end
            chk("ack_data", {31'b0, er, rd}, {31'b0, e.err, e.rdata});
        end
    endtask

    // Monitor: compare each ack against the scoreboard head.
    always @(negedge clk) begin
        if (a_ack && b_ack) begin
            total++;
            bad++;
            $display("FAIL both_acks cyc=%0d got a=1 b=1 exp at most one", cyc);
        end
        if (a_ack)  check_ack(0, 1'b0, a_rdata, a_err);
        if (b_ack)  check_ack(0, 1'b1, b_rdata, b_err);
        if (a3_ack) check_ack(3, 1'b0, a3_rdata, a3_err);
        if (b3_ack) check_ack(3, 1'b1, b3_rdata, b3_err);
    end

    task automatic push(input int d, input bit pb, input logic [31:0] rd, input logic er, input int c);
        exp_t e;
        e.dut = d; e.port_b = pb; e.rdata = rd; e.err = er; e.cyc = c;
        sb.push_back(e);
    endtask

    // Run until every expected ack has been seen, dropping each request
    // right after its ack; a stuck scoreboard counts as a failure.
    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
            if (a_ack)  a_req  = 1'b0;
            if (b_ack)  b_req  = 1'b0;
            if (a3_ack) a3_req = 1'b0;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
            a_req = 1'b0; b_req = 1'b0; a3_req = 1'b0;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          we0;
        logic [31:0] bmod;

        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; b_wdata = '0;
        a3_req = 1'b0; a3_addr = '0;
        bmod = '0;

        // Reset state: every output low.
        repeat (3) @(negedge clk);
        chk("rst_strobes", {59'b0, a_ack, a_err, b_ack, b_err, ram_we}, 64'd0);
        chk("rst_data", {32'b0, a_rdata | b_rdata | ram_din}, 64'd0);
        chk("rst_ram_addr", {47'b0, ram_addr}, 64'd0);
        rst_n = 1'b1;
        we0 = we_cnt0;

        // Contention from reset: B first at +3, held A at +7.
        @(negedge clk);
        c = cyc;
        a_addr = 32'h10; b_addr = 32'h10; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        push(0, 1'b1, 32'hDEADBEEF, 1'b0, c + 3);
        push(0, 1'b0, 32'hDEADBEEF, 1'b0, c + 7);
        bmod = 32'hDEADBEEF;
        drain(30);

        // Lone fetch: ack at +3, no RAM write anywhere so far.
        @(negedge clk);
        c = cyc;
        a_addr = 32'h10; a_req = 1'b1;
        push(0, 1'b0, 32'hDEADBEEF, 1'b0, c + 3);
        drain(20);
        chk("reads_no_write", 64'(we_cnt0 - we0), 64'd0);

        // Store 0x12345678 -> 0x20: one write strobe in ACCESS, rdata kept.
        @(negedge clk);
        c = cyc;
        we0 = we_cnt0;
        b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h12345678; b_req = 1'b1;
        push(0, 1'b1, bmod, 1'b0, c + 3);
        drain(20);
        chk("store_we_count", 64'(we_cnt0 - we0), 64'd1);
        chk("store_we_cycle", 64'(last_we_cyc0), 64'(c + 1));
        chk("store_we_addr", {47'b0, last_we_addr0}, 64'h20);
        chk("store_we_din", {32'b0, last_we_din0}, 64'h12345678);

        // Load back from 0x20.
        @(negedge clk);
        c = cyc;
        b_we = 1'b0; b_addr = 32'h20; b_req = 1'b1;
        push(0, 1'b1, 32'h12345678, 1'b0, c + 3);
        bmod = 32'h12345678;
        drain(20);

        // B was served last, so this contention goes to A first.
        @(negedge clk);
        c = cyc;
        a_addr = 32'h10; b_addr = 32'h20; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        push(0, 1'b0, 32'hDEADBEEF, 1'b0, c + 3);
        push(0, 1'b1, 32'h12345678, 1'b0, c + 7);
        drain(30);

        // WAIT_STATES=3: ack at +6, RAM address stable in cycles 1..5.
        @(negedge clk);
        c = cyc;
        a3_addr = 32'h10; a3_req = 1'b1;
        push(3, 1'b0, 32'h0BADF00D, 1'b0, c + 6);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("ws3_addr_hold", {47'b0, ram3_addr}, 64'h10);
        end
        drain(20);
        chk("ws3_no_write", 64'(we_cnt3), 64'd0);

        // Reset during ACCESS of a store: outputs drop at once, no ack.
        @(negedge clk);
        c = cyc;
        b_we = 1'b1; b_addr = 32'h30; b_wdata = 32'hAAAA5555; b_req = 1'b1;
        @(negedge clk);
        chk("mid_access_we", {63'b0, ram_we}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {59'b0, a_ack, a_err, b_ack, b_err, ram_we}, 64'd0);
        chk("mid_rst_data", {32'b0, b_rdata | a_rdata | ram_din}, 64'd0);
        b_req = 1'b0; b_we = 1'b0;
        bmod = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // After reset: normal service resumes.
        @(negedge clk);
        c = cyc;
        a_addr = 32'h10; a_req = 1'b1;
        push(0, 1'b0, 32'hDEADBEEF, 1'b0, c + 3);
        drain(20);
        @(negedge clk);
        c = cyc;
        b_we = 1'b0; b_addr = 32'h20; b_req = 1'b1;
        push(0, 1'b1, 32'h12345678, 1'b0, c + 3);
        bmod = 32'h12345678;
        drain(20);

        // Store above the RAM range.
        @(negedge clk);
        c = cyc;
        we0 = we_cnt0;
        b_we = 1'b1; b_addr = 32'h00020000; b_wdata = 32'hCAFEF00D; b_req = 1'b1;
`ifdef MEM_RESP_ADDR_CHECK_EN
        push(0, 1'b1, 32'h0, 1'b1, c + 1);
        bmod = '0;
        drain(20);
        chk("oor_no_write", 64'(we_cnt0 - we0), 64'd0);
`else
        push(0, 1'b1, bmod, 1'b0, c + 3);
        drain(20);
        chk("alias_we_count", 64'(we_cnt0 - we0), 64'd1);
        chk("alias_we_addr", {47'b0, last_we_addr0}, 64'h0);
        @(negedge clk);
        c = cyc;
        b_we = 1'b0; b_addr = 32'h0; b_req = 1'b1;
        push(0, 1'b1, 32'hCAFEF00D, 1'b0, c + 3);
        drain(20);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cpu's two memory request ports: port A (instruction fetch, read-only) and port B (data load/store).
- Arbitrates round-robin between the two ports and serialises accesses onto one single-port synchronous RAM.
- Sits between cpu and ram in riscv_top and adds configurable wait states to model slower memory.

Parameters:
- ADDR_WIDTH, 32, cpu address width.
- DATA_WIDTH, 32, data word width.
- RAM_ADDR_WIDTH, 17, RAM index width; RAM address is addr[RAM_ADDR_WIDTH-1:0].
- WAIT_STATES, 0, extra RAM cycles per access (0..15).

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- a_req_in  input  1  port A request; held high with stable address until ack.
- a_addr_in  input  ADDR_WIDTH  port A address.
- a_ack_out  output  1  one-cycle pulse; a_rdata_out valid in the same cycle.
- a_rdata_out  output  DATA_WIDTH  port A read data.
- a_err_out  output  1  address error, pulses with a_ack_out.
- b_req_in  input  1  port B request; held high with stable addr/we/wdata until ack.
- b_we_in  input  1  1 = store, 0 = load.
- b_addr_in  input  ADDR_WIDTH  port B address.
- b_wdata_in  input  DATA_WIDTH  store data.
- b_ack_out  output  1  one-cycle completion pulse.
- b_rdata_out  output  DATA_WIDTH  load data.
- b_err_out  output  1  address error, pulses with b_ack_out.
- ram_addr_out  output  RAM_ADDR_WIDTH  RAM address.
- ram_we_out  output  1  RAM write enable.
- ram_din_out  output  DATA_WIDTH  RAM write data.
- ram_dout_in  input  DATA_WIDTH  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Reset (rst_in low, asynchronous):
  - FSM goes to IDLE; all outputs 0.
  - last_grant = A; wait counter = 0.
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE:
  - Eligible port: req high and its ack_out low in this cycle. A req seen during its own ack cycle is ignored.
  - Only one port eligible: grant it.
  - Both eligible: grant the port not equal to last_grant, so B wins the first contention after reset.
  - On grant: latch port id, addr, we (A is always read) and wdata; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - ram_addr_out = latched addr[RAM_ADDR_WIDTH-1:0].
  - ram_we_out = latched we; ram_din_out = latched wdata.
  - Next state: WAIT with counter = WAIT_STATES.
- WAIT (1+WAIT_STATES cycles):
  - ram_addr_out held; ram_we_out = 0.
  - Counter decrements each cycle; at 0, go to RESP.
  - On the edge entering RESP, capture ram_dout_in into the granted port's rdata (loads and fetches only).
- RESP (1 cycle):
  - Granted port's ack_out = 1; next state IDLE.
  - Stores leave b_rdata_out unchanged.
- Timing:
  - Request accepted in IDLE at cycle 0 gives ack in cycle 3+WAIT_STATES.
  - Next grant is evaluated in cycle 4+WAIT_STATES; one access per 4+WAIT_STATES cycles.
- rdata_out registers hold their value between acks.
- Never both acks in the same cycle; at most one access outstanding.
- Request dropped before ack: the access still completes and acks (requester protocol violation; no abort).
- Reset mid-access: ram_we_out falls immediately and no ack is issued. A store interrupted in ACCESS may or may not land; the requester must reissue.

Optional Feature:
- Macro: MEM_RESP_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a granted request with addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH] != 0 skips ACCESS/WAIT and goes directly to RESP.
  - Result: ack plus err pulse in cycle 1, rdata_out = 0, no RAM write.
  - last_grant is still updated.
- Undefined:
  - Upper address bits are ignored and the RAM aliases.
  - a_err_out and b_err_out are tied 0.

Test Plan:
- WAIT_STATES=0, RAM[0x10]=0xDEADBEEF, a_req with addr 0x10 at cycle 0 -> a_ack_out and a_rdata_out=0xDEADBEEF in cycle 3; ram_we_out never high.
- Port B store 0x12345678 to 0x20, then load from 0x20 -> ram_we_out high exactly one cycle (ACCESS, ram_addr_out=0x20); load acks with 0x12345678.
- A and B request simultaneously from reset, both held -> B acked in cycle 3, A acked in cycle 7. Then both request again -> A first (alternation).
- WAIT_STATES=3, single fetch -> ack in cycle 6; ram_addr_out stable in cycles 1-5.
- rst_in pulsed low during ACCESS of a store -> all outputs 0 immediately; no ack; after release FSM is IDLE and accepts a new request normally.
- MEM_RESP_ADDR_CHECK_EN defined, b store to 0x00020000 -> b_ack_out and b_err_out high in cycle 1, ram_we_out never high. Without the macro: write lands at RAM index 0, err_out stays 0.
